// File: rtl/sram_rmw_arbiter_if.sv
// Requester-side bundle for sram_rmw_arbiter: inference read port and learning
// update port. master = requesters, slave = arbiter.
interface sram_rmw_arbiter_if #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32,
  parameter int SYN_WIDTH  = 8,
  parameter int LANE_W     = 2
);
  // Handshake: a requester raises *_req with stable payload and holds it until
  // the combinational *_gnt is seen high in the same cycle; the request is taken
  // at that clock edge and req must drop (or present a new request) next cycle.
  logic                  rd_req;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic                  rd_gnt;
  logic                  rd_valid;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  upd_req;
  logic [ADDR_WIDTH-1:0] upd_addr;
  logic [LANE_W-1:0]     upd_lane;
  logic [SYN_WIDTH-1:0]  upd_delta;
  logic                  upd_gnt;
  logic                  upd_done;

  modport master (
    output rd_req, rd_addr, upd_req, upd_addr, upd_lane, upd_delta,
    input  rd_gnt, rd_valid, rd_data, upd_gnt, upd_done
  );

  modport slave (
    input  rd_req, rd_addr, upd_req, upd_addr, upd_lane, upd_delta,
    output rd_gnt, rd_valid, rd_data, upd_gnt, upd_done
  );
endinterface

// File: rtl/sram_rmw_arbiter.sv
// Single-port weight SRAM arbiter: pipelined inference reads plus atomic
// saturating lane read-modify-write. SRAM_ARB_INIT_CLEAR_EN adds a zeroing sweep.
module sram_rmw_arbiter #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32,
  parameter int SRAM_DEPTH = 256,
  parameter int SYN_WIDTH  = 8,
  parameter int LANE_W     = 2
) (
  input  logic                  CK,
  input  logic                  RST,
  sram_rmw_arbiter_if.slave     bus,
  output logic                  busy,
  output logic                  init_done,
  output logic                  SRAM_CS,
  output logic                  SRAM_WE,
  output logic [ADDR_WIDTH-1:0] SRAM_A,
  output logic [DATA_WIDTH-1:0] SRAM_D,
  input  logic [DATA_WIDTH-1:0] SRAM_Q,
  output logic [2:0]            dbg_state
);

`ifdef SRAM_ARB_INIT_CLEAR_EN
  typedef enum logic [2:0] {
    S_IDLE = 3'd0, S_U_RD = 3'd1, S_U_MOD = 3'd2, S_U_WR = 3'd3, S_INIT = 3'd4
  } state_t;
  localparam state_t S_RESET = S_INIT;
`else
  typedef enum logic [2:0] {
    S_IDLE = 3'd0, S_U_RD = 3'd1, S_U_MOD = 3'd2, S_U_WR = 3'd3
  } state_t;
  localparam state_t S_RESET = S_IDLE;
`endif

  state_t                state_q, state_d;
  logic                  prio_q, prio_d;
  logic [LANE_W-1:0]     lane_q, lane_d;
  logic [SYN_WIDTH-1:0]  delta_q, delta_d;
  logic                  cs_d, we_d;
  logic [ADDR_WIDTH-1:0] a_d;
  logic [DATA_WIDTH-1:0] d_d;
  logic                  rd_gnt_c, upd_gnt_c;
  logic                  rd_pipe_q, rd_valid_q;
  logic                  upd_done_q, upd_done_d;
  logic [SYN_WIDTH-1:0]  old_lane, sat_lane;
  logic [SYN_WIDTH:0]    sum;
  logic [DATA_WIDTH-1:0] mod_word;

`ifdef SRAM_ARB_INIT_CLEAR_EN
  logic [ADDR_WIDTH:0]   init_cnt_q, init_cnt_d;
  logic                  init_done_q, init_done_d;
`endif

  // Sign-extend to SYN_WIDTH+1 bits; the two top bits disagree only on overflow.
  always_comb begin
    old_lane = SRAM_Q[lane_q*SYN_WIDTH +: SYN_WIDTH];
    sum      = {old_lane[SYN_WIDTH-1], old_lane} + {delta_q[SYN_WIDTH-1], delta_q};
    if (sum[SYN_WIDTH] != sum[SYN_WIDTH-1])
      sat_lane = sum[SYN_WIDTH] ? {1'b1, {(SYN_WIDTH-1){1'b0}}} : {1'b0, {(SYN_WIDTH-1){1'b1}}};
    else
      sat_lane = sum[SYN_WIDTH-1:0];
    mod_word = SRAM_Q;
    mod_word[lane_q*SYN_WIDTH +: SYN_WIDTH] = sat_lane;
  end

  always_comb begin
    state_d    = state_q;
    prio_d     = prio_q;
    lane_d     = lane_q;
    delta_d    = delta_q;
    cs_d       = 1'b0;
    we_d       = 1'b0;
    a_d        = SRAM_A;
    d_d        = SRAM_D;
    rd_gnt_c   = 1'b0;
    upd_gnt_c  = 1'b0;
    upd_done_d = 1'b0;
`ifdef SRAM_ARB_INIT_CLEAR_EN
    init_cnt_d  = init_cnt_q;
    init_done_d = init_done_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (bus.rd_req && (!bus.upd_req || !prio_q)) begin
          rd_gnt_c = 1'b1;
          prio_d   = 1'b1;
          cs_d     = 1'b1;
          a_d      = bus.rd_addr;
        end else if (bus.upd_req) begin
          upd_gnt_c = 1'b1;
          prio_d    = 1'b0;
          cs_d      = 1'b1;
          a_d       = bus.upd_addr;
          lane_d    = bus.upd_lane;
          delta_d   = bus.upd_delta;
          state_d   = S_U_RD;
        end
      end
      S_U_RD: state_d = S_U_MOD;
      // SRAM_Q holds the old word now; SRAM_A still holds the update address.
      S_U_MOD: begin
        cs_d       = 1'b1;
        we_d       = 1'b1;
        d_d        = mod_word;
        upd_done_d = 1'b1;
        state_d    = S_U_WR;
      end
      S_U_WR: state_d = S_IDLE;
`ifdef SRAM_ARB_INIT_CLEAR_EN
      S_INIT: begin
        if (init_cnt_q == (ADDR_WIDTH+1)'(SRAM_DEPTH)) begin
          init_done_d = 1'b1;
          state_d     = S_IDLE;
        end else begin
          cs_d       = 1'b1;
          we_d       = 1'b1;
          a_d        = init_cnt_q[ADDR_WIDTH-1:0];
          d_d        = '0;
          init_cnt_d = init_cnt_q + 1'b1;
        end
      end
`endif
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CK) begin
    if (RST) begin
      state_q    <= S_RESET;
      prio_q     <= 1'b0;
      lane_q     <= '0;
      delta_q    <= '0;
      SRAM_CS    <= 1'b0;
      SRAM_WE    <= 1'b0;
      SRAM_A     <= '0;
      SRAM_D     <= '0;
      rd_pipe_q  <= 1'b0;
      rd_valid_q <= 1'b0;
      upd_done_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      prio_q     <= prio_d;
      lane_q     <= lane_d;
      delta_q    <= delta_d;
      SRAM_CS    <= cs_d;
      SRAM_WE    <= we_d;
      SRAM_A     <= a_d;
      SRAM_D     <= d_d;
      rd_pipe_q  <= rd_gnt_c;
      rd_valid_q <= rd_pipe_q;
      upd_done_q <= upd_done_d;
    end
  end

`ifdef SRAM_ARB_INIT_CLEAR_EN
  always_ff @(posedge CK) begin
    if (RST) begin
      init_cnt_q  <= '0;
      init_done_q <= 1'b0;
    end else begin
      init_cnt_q  <= init_cnt_d;
      init_done_q <= init_done_d;
    end
  end
  assign init_done = init_done_q;
`else
  assign init_done = (SRAM_DEPTH > 0);
`endif

  assign bus.rd_gnt   = rd_gnt_c;
  assign bus.upd_gnt  = upd_gnt_c;
  assign bus.rd_valid = rd_valid_q;
  assign bus.rd_data  = SRAM_Q;
  assign bus.upd_done = upd_done_q;
  assign busy         = (state_q != S_IDLE);
  assign dbg_state    = state_q;

endmodule

// File: tb/tb_sram_rmw_arbiter.sv
// Directed bench for sram_rmw_arbiter with a behavioural 1-cycle SRAM model.
// Inputs are driven on the falling edge and outputs checked 1 time unit later.
module tb_sram_rmw_arbiter;
  localparam int AW = 8, DW = 32, SW = 8, LW = 2, DEPTH = 256;

`ifdef SRAM_ARB_INIT_CLEAR_EN
  localparam logic       EXP_BUSY_RST = 1'b1;
  localparam logic       EXP_INIT_RST = 1'b0;
  localparam logic [2:0] EXP_ST_RST   = 3'd4;
`else
  localparam logic       EXP_BUSY_RST = 1'b0;
  localparam logic       EXP_INIT_RST = 1'b1;
  localparam logic [2:0] EXP_ST_RST   = 3'd0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          busy, init_done, sram_cs, sram_we;
  logic [AW-1:0] sram_a;
  logic [DW-1:0] sram_d, sram_q;
  logic [2:0]    dbg_state;

  int n_cmp = 0;
  int n_err = 0;

  sram_rmw_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .SYN_WIDTH(SW), .LANE_W(LW)) bus ();

  sram_rmw_arbiter #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .SRAM_DEPTH(DEPTH), .SYN_WIDTH(SW), .LANE_W(LW)
  ) dut (
    .CK(clk), .RST(rst), .bus(bus), .busy(busy), .init_done(init_done),
    .SRAM_CS(sram_cs), .SRAM_WE(sram_we), .SRAM_A(sram_a), .SRAM_D(sram_d),
    .SRAM_Q(sram_q), .dbg_state(dbg_state)
  );

  // clock
  always #5 clk = ~clk;

  // SRAM model with a bench-only preload port
  logic [DW-1:0] mem [0:DEPTH-1];
  logic          pre_we = 1'b0;
  logic [AW-1:0] pre_addr = '0;
  logic [DW-1:0] pre_data = '0;
  int            wr_cnt = 0;

  always @(posedge clk) begin
    if (pre_we) mem[pre_addr] <= pre_data;
    else if (sram_cs) begin
      if (sram_we) mem[sram_a] <= sram_d;
      else         sram_q <= mem[sram_a];
    end
    if (sram_cs && sram_we) wr_cnt <= wr_cnt + 1;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: observed no finish expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic preload(input logic [AW-1:0] a, input logic [DW-1:0] d);
    pre_we = 1'b1; pre_addr = a; pre_data = d;
    @(negedge clk);
    pre_we = 1'b0;
  endtask

  task automatic preload_all();
    for (int i = 0; i < 4; i++) preload(AW'(i), 32'hA000_0000 + i);
    preload(8'd5,  32'h1122_3344);
    preload(8'd7,  32'h7F80_0010);
    preload(8'd9,  32'h0000_0005);
    preload(8'd12, 32'h0102_0304);
  endtask

  task automatic wait_init();
`ifdef SRAM_ARB_INIT_CLEAR_EN
    int k = 0;
    while (!init_done && k < DEPTH + 20) begin
      @(negedge clk); k++;
    end
    #1 chk("init_wait", init_done, 1);
`endif
  endtask

  task automatic do_reset();
    bus.rd_req = 1'b0; bus.upd_req = 1'b0; rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    wait_init();
    preload_all();
  endtask

  task automatic do_rd(input logic [AW-1:0] a, input logic [DW-1:0] exp);
    @(negedge clk); bus.rd_req = 1'b1; bus.rd_addr = a; #1;
    chk("rd_gnt", bus.rd_gnt, 1);
    @(negedge clk); bus.rd_req = 1'b0; #1;
    chk("rd_c1_valid", bus.rd_valid, 0);
    chk("rd_c1_sram", {sram_cs, sram_we, sram_a}, {1'b1, 1'b0, a});
    @(negedge clk); #1;
    chk("rd_c2_valid", bus.rd_valid, 1);
    chk("rd_c2_data", bus.rd_data, exp);
    @(negedge clk); #1;
    chk("rd_c3_valid", bus.rd_valid, 0);
  endtask

  task automatic do_upd(input logic [AW-1:0] a, input logic [LW-1:0] ln,
                        input logic [SW-1:0] dl, input logic [DW-1:0] exp);
    @(negedge clk);
    bus.upd_req = 1'b1; bus.upd_addr = a; bus.upd_lane = ln; bus.upd_delta = dl; #1;
    chk("upd_gnt", {bus.upd_gnt, bus.rd_gnt, busy}, 3'b100);
    @(negedge clk); bus.upd_req = 1'b0; #1;
    chk("upd_c1", {dbg_state, busy, sram_cs, sram_we, bus.upd_done}, {3'd1, 4'b1100});
    chk("upd_c1_a", sram_a, a);
    @(negedge clk); #1;
    chk("upd_c2", {dbg_state, sram_cs, bus.upd_done}, {3'd2, 2'b00});
    @(negedge clk); #1;
    chk("upd_c3", {sram_cs, sram_we, bus.upd_done, sram_a}, {3'b111, a});
    chk("upd_c3_d", sram_d, exp);
    @(negedge clk); #1;
    chk("upd_c4", {bus.upd_done, busy}, 2'b00);
    chk("upd_mem", mem[a], exp);
  endtask

  initial begin
    rst = 1'b1;
    bus.rd_req = 1'b0; bus.rd_addr = '0;
    bus.upd_req = 1'b0; bus.upd_addr = '0; bus.upd_lane = '0; bus.upd_delta = '0;

    // reset state
    repeat (3) @(negedge clk);
    #1;
    chk("rst_valid_done", {bus.rd_valid, bus.upd_done}, 2'b00);
    chk("rst_sram_ctl", {sram_cs, sram_we, sram_a}, '0);
    chk("rst_sram_d", sram_d, 32'h0);
    chk("rst_busy", busy, EXP_BUSY_RST);
    chk("rst_init_done", init_done, EXP_INIT_RST);
    chk("rst_state", dbg_state, EXP_ST_RST);
    @(negedge clk);
    rst = 1'b0;

`ifdef SRAM_ARB_INIT_CLEAR_EN
    begin : init_sweep
      int  k;
      bit  seen;
      k = 0; seen = 1'b0;
      bus.rd_req = 1'b1; bus.rd_addr = 8'd5;
      while (!seen && k < DEPTH + 10) begin
        @(negedge clk); k++; #1;
        chk("init_gnt", bus.rd_gnt, (k == DEPTH + 1));
        if (k == 1) chk("init_first_wr", {sram_cs, sram_we, sram_a}, {2'b11, 8'd0});
        if (init_done) seen = 1'b1;
      end
      chk("init_len", k, DEPTH + 1);
      @(negedge clk); bus.rd_req = 1'b0;
      @(negedge clk); #1;
      chk("init_rd_zero", {31'd0, bus.rd_valid} ^ bus.rd_data, 32'h1);
    end
`else
    @(negedge clk);
`endif
    preload_all();

    // single read
    do_rd(8'd5, 32'h1122_3344);

    // burst of four back-to-back reads
    for (int c = 0; c < 7; c++) begin
      @(negedge clk);
      bus.rd_req = (c < 4); bus.rd_addr = AW'(c); #1;
      if (c < 4) chk("burst_gnt", bus.rd_gnt, 1);
      if (c >= 2 && c < 6) begin
        chk("burst_valid", bus.rd_valid, 1);
        chk("burst_data", bus.rd_data, 32'hA000_0000 + (c - 2));
      end else chk("burst_idle", bus.rd_valid, 0);
    end
    bus.rd_req = 1'b0;

    // saturating updates on word 7
    do_upd(8'd7, 2'd0, 8'h7F, 32'h7F80_007F);
    do_upd(8'd7, 2'd2, 8'hFF, 32'h7F80_007F);
    do_upd(8'd7, 2'd3, 8'h05, 32'h7F80_007F);
    do_upd(8'd7, 2'd1, 8'hFD, 32'h7F80_FD7F);
    do_rd(8'd7, 32'h7F80_FD7F);

    // contention from reset: read wins, then held update beats the next read
    do_reset();
    @(negedge clk);
    bus.rd_req = 1'b1; bus.rd_addr = 8'd9;
    bus.upd_req = 1'b1; bus.upd_addr = 8'd9; bus.upd_lane = 2'd0; bus.upd_delta = 8'd3; #1;
    chk("cont_c0", {bus.rd_gnt, bus.upd_gnt}, 2'b10);
    @(negedge clk); #1;
    chk("cont_c1", {bus.rd_gnt, bus.upd_gnt}, 2'b01);
    @(negedge clk); bus.upd_req = 1'b0; #1;
    chk("cont_c2_rd", {bus.rd_valid, bus.rd_gnt}, 2'b10);
    chk("cont_c2_data", bus.rd_data, 32'h5);
    chk("cont_c2_sram", {sram_cs, sram_we, sram_a}, {2'b10, 8'd9});
    @(negedge clk); #1;
    chk("cont_c3", {sram_cs, bus.rd_gnt, bus.rd_valid}, 3'b000);
    @(negedge clk); #1;
    chk("cont_c4", {sram_cs, sram_we, bus.upd_done, bus.rd_gnt}, 4'b1110);
    chk("cont_c4_d", sram_d, 32'h8);
    @(negedge clk); #1;
    chk("cont_c5_gnt", bus.rd_gnt, 1);
    @(negedge clk); bus.rd_req = 1'b0;
    @(negedge clk); #1;
    chk("cont_rd_new", {bus.rd_valid, bus.rd_data}, {1'b1, 32'h8});

    // reset asserted while in U_MOD
    @(negedge clk);
    bus.upd_req = 1'b1; bus.upd_addr = 8'd12; bus.upd_lane = 2'd0; bus.upd_delta = 8'd1; #1;
    chk("abort_gnt", bus.upd_gnt, 1);
    @(negedge clk); bus.upd_req = 1'b0;
    @(negedge clk); #1;
    chk("abort_in_mod", dbg_state, 3'd2);
    begin : abort_chk
      int w0;
      w0 = wr_cnt;
      rst = 1'b1;
      @(negedge clk); rst = 1'b0; #1;
      chk("abort_sram", {sram_cs, sram_we, sram_a}, '0);
      chk("abort_d", sram_d, 32'h0);
      chk("abort_flags", {bus.rd_valid, bus.upd_done, busy}, {2'b00, EXP_BUSY_RST});
      chk("abort_state", dbg_state, EXP_ST_RST);
      @(negedge clk); #1;
      chk("abort_no_wr", wr_cnt, w0);
      chk("abort_mem", mem[12], 32'h0102_0304);
    end
    wait_init();

    // reset clears an in-flight read
    @(negedge clk); bus.rd_req = 1'b1; bus.rd_addr = 8'd3; #1;
    chk("flush_gnt", bus.rd_gnt, 1);
    @(negedge clk); bus.rd_req = 1'b0; rst = 1'b1;
    @(negedge clk); rst = 1'b0; #1;
    chk("flush_valid", bus.rd_valid, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
